// File: rtl/dcache_wb_ctrl.sv
// ============================================================================
// Module   : dcache_wb_ctrl
// Brief    : Direct-mapped write-back / write-allocate data cache controller.
//            Optional hit/miss statistics counters: macro CACHE_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_wb_ctrl #(
  parameter int TAG_LEN           = 2,
  parameter int INDEX_ADDR_LEN    = 6,
  parameter int LINEWORD_ADDR_LEN = 2,
  parameter int MEM_ADDR_LEN      = TAG_LEN + INDEX_ADDR_LEN
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                cpu_rd_req,
  input  logic                                cpu_wr_req,
  input  logic [31:0]                         cpu_addr,
  input  logic [31:0]                         cpu_wr_data,
  output logic [31:0]                         cpu_rd_data,
  output logic                                miss,
  output logic                                mem_rd_req,
  output logic                                mem_wr_req,
  output logic [MEM_ADDR_LEN-1:0]             mem_addr,
  output logic [(32<<LINEWORD_ADDR_LEN)-1:0]  wr_line,
  input  logic [(32<<LINEWORD_ADDR_LEN)-1:0]  rd_line,
  input  logic                                mem_handshake,
  output logic [31:0]                         hit_cnt,
  output logic [31:0]                         miss_cnt
);

  localparam int LINES   = 1 << INDEX_ADDR_LEN;
  localparam int LINE_W  = 32 << LINEWORD_ADDR_LEN;
  localparam int IDX_LO  = LINEWORD_ADDR_LEN + 2;
  localparam int TAG_LO  = IDX_LO + INDEX_ADDR_LEN;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_ALLOCATE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LINE_W-1:0]         data_q  [LINES];
  logic [TAG_LEN-1:0]        tag_q   [LINES];
  logic [LINES-1:0]          valid_q;
  logic [LINES-1:0]          dirty_q;

  logic [LINEWORD_ADDR_LEN-1:0] word_off;
  logic [INDEX_ADDR_LEN-1:0]    index;
  logic [TAG_LEN-1:0]           tag;
  logic [LINEWORD_ADDR_LEN+4:0] bit_off;
  logic                         req;
  logic                         hit;
  logic                         wr_hit;
  logic                         fill;
  logic                         unused_addr_bits;

  assign word_off = cpu_addr[IDX_LO-1:2];
  assign index    = cpu_addr[TAG_LO-1:IDX_LO];
  assign tag      = cpu_addr[TAG_LO+TAG_LEN-1:TAG_LO];
  assign bit_off  = {word_off, 5'b0};
  assign unused_addr_bits = ^{cpu_addr[31:TAG_LO+TAG_LEN], cpu_addr[1:0]};

  assign req    = cpu_rd_req | cpu_wr_req;
  assign hit    = valid_q[index] && (tag_q[index] == tag);
  assign wr_hit = (state_q == S_IDLE) && cpu_wr_req && hit;
  assign fill   = (state_q == S_ALLOCATE) && mem_handshake;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss        = 1'b0;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = {tag, index};
    wr_line     = data_q[index];
    cpu_rd_data = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous read+write is a write; read data stays at zero.
            if (cpu_rd_req && !cpu_wr_req) begin
              cpu_rd_data = data_q[index][bit_off +: 32];
            end
          end else begin
            miss    = 1'b1;
            state_d = (valid_q[index] && dirty_q[index]) ? S_WRITE_BACK : S_ALLOCATE;
          end
        end
      end
      S_WRITE_BACK: begin
        miss       = 1'b1;
        mem_wr_req = 1'b1;
        mem_addr   = {tag_q[index], index};
        if (mem_handshake) begin
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        miss       = 1'b1;
        mem_rd_req = 1'b1;
        if (mem_handshake) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Data and tags survive reset; only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[index] <= rd_line;
      tag_q[index]  <= tag;
    end else if (wr_hit) begin
      data_q[index][bit_off +: 32] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[index] <= 1'b1;
    end
  end

`ifdef CACHE_STAT_EN
  logic        relookup_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The first IDLE cycle after a fill is the stalled request re-looking up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      relookup_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      relookup_q <= fill;
      if ((state_q == S_IDLE) && req && hit && !relookup_q && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == S_IDLE) && req && !hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb_ctrl.sv
// ============================================================================
// Module   : tb_dcache_wb_ctrl
// Brief    : Self-checking bench for dcache_wb_ctrl with a line-memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_wb_ctrl;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cpu_rd_req = 1'b0;
  logic         cpu_wr_req = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wr_data = '0;
  logic [31:0]  cpu_rd_data;
  logic         miss;
  logic         mem_rd_req;
  logic         mem_wr_req;
  logic [7:0]   mem_addr;
  logic [127:0] wr_line;
  logic [127:0] rd_line = '0;
  logic         mem_handshake = 1'b0;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  always #5 clk = ~clk;

  dcache_wb_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .miss(miss), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .wr_line(wr_line), .rd_line(rd_line),
    .mem_handshake(mem_handshake), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  logic [127:0] backing [256];
  logic [127:0] arch    [256];
  logic [31:0]  exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int           wr_cnt = 0;
  int           rd_cnt = 0;
  logic [7:0]   last_wr_addr = '0;
  logic [7:0]   last_rd_addr = '0;
  logic [127:0] last_wr_line = '0;

  // Memory model: answers each request LAT cycles after it appears.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_handshake = 1'b0;
      if (!rstn) begin
        cnt = 0;
      end else if (mem_rd_req || mem_wr_req) begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          mem_handshake = 1'b1;
          if (mem_wr_req) begin
            backing[mem_addr] = wr_line;
            last_wr_addr = mem_addr;
            last_wr_line = wr_line;
            wr_cnt++;
          end else begin
            rd_line = backing[mem_addr];
            last_rd_addr = mem_addr;
            rd_cnt++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind: 0 = read, 1 = write, 2 = read and write together
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] data,
                        input bit exp_miss, input bit exp_wb, input string name);
    int wr0, stall, exp_stall;
    bit done, both;
    logic [7:0] la;
    logic [6:0] off;
    logic [31:0] exp_d;
    wr0 = wr_cnt; stall = 0; done = 0; both = 0;
    la = addr[11:4];
    off = {addr[3:2], 5'b0};
    cpu_addr = addr; cpu_wr_data = data;
    cpu_rd_req = (kind != 1); cpu_wr_req = (kind != 0);
    if (kind == 0) exp_q.push_back(arch[la][off +: 32]);
    else arch[la][off +: 32] = data;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mem_rd_req && mem_wr_req) both = 1;
      if (miss) stall++;
      else done = 1;
    end
    exp_stall = exp_miss ? (exp_wb ? 1 + 2*LAT : 1 + LAT) : 0;
    tests++;
    if (!done) begin
      fails++; $display("FAIL %s timeout: miss still %0b after 200 cycles, required 0", name, miss);
    end
    tests++;
    if (stall !== exp_stall) begin
      fails++; $display("FAIL %s stall: got %0d cycles, required %0d", name, stall, exp_stall);
    end
    tests++;
    if ((wr_cnt != wr0) !== exp_wb) begin
      fails++; $display("FAIL %s writeback: got %0d writes, required %0d", name, wr_cnt - wr0, exp_wb);
    end
    tests++;
    if (both) begin
      fails++; $display("FAIL %s reqs: mem_rd_req and mem_wr_req both 1, required exclusive", name);
    end
    if (kind == 0 && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      tests++;
      if (cpu_rd_data !== exp_d) begin
        fails++; $display("FAIL %s rdata: got %h, required %h", name, cpu_rd_data, exp_d);
      end
    end
    @(posedge clk); #1;
    cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({miss, mem_rd_req, mem_wr_req} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got miss/rd/wr=%b, required 000", {miss, mem_rd_req, mem_wr_req});
    end
    tests++;
    if (cpu_rd_data !== 32'h0) begin
      fails++; $display("FAIL reset_rdata: got %h, required 00000000", cpu_rd_data);
    end
    tests++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      fails++; $display("FAIL reset_cnt: got hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int l = 0; l < 256; l++) arch[l] = backing[l];
  endtask

  task automatic test_cold_read();
    access(0, 32'h000, 32'h0, 1, 0, "cold_read");
    tests++;
    if (last_rd_addr !== 8'h00) begin
      fails++; $display("FAIL cold_addr: got %h, required 00", last_rd_addr);
    end
    access(0, 32'h00C, 32'h0, 0, 0, "hit_read_w3");
  endtask

  task automatic test_write_hit();
    int rd0;
    rd0 = rd_cnt;
    access(1, 32'h004, 32'hDEADBEEF, 0, 0, "write_hit");
    access(0, 32'h004, 32'h0, 0, 0, "read_after_write");
    tests++;
    if (rd_cnt !== rd0) begin
      fails++; $display("FAIL write_hit_memreq: got %0d reads, required 0", rd_cnt - rd0);
    end
  endtask

  task automatic test_conflict();
    access(0, 32'h400, 32'h0, 1, 1, "dirty_conflict");
    tests++;
    if (last_wr_addr !== 8'h00 || last_wr_line[63:32] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL victim: got addr %h word1 %h, required 00 deadbeef", last_wr_addr, last_wr_line[63:32]);
    end
    tests++;
    if (last_rd_addr !== 8'h40) begin
      fails++; $display("FAIL conflict_fetch: got %h, required 40", last_rd_addr);
    end
    access(0, 32'h000, 32'h0, 1, 0, "clean_conflict");
    access(0, 32'h004, 32'h0, 0, 0, "refetched_word");
  endtask

  task automatic test_write_miss();
    access(1, 32'h010, 32'h12345678, 1, 0, "write_miss");
    tests++;
    if (last_rd_addr !== 8'h01) begin
      fails++; $display("FAIL write_miss_addr: got %h, required 01", last_rd_addr);
    end
    access(0, 32'h010, 32'h0, 0, 0, "read_write_miss");
  endtask

  task automatic test_back_to_back();
    access(2, 32'h018, 32'hA5A50018, 0, 0, "rd_wr_both");
    for (int i = 0; i < 4; i++) begin
      access(0, 32'h010 + 32'(i*4), 32'h0, 0, 0, "b2b_read");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    access(1, 32'h004, 32'hCAFEF00D, 0, 0, "dirty_again");
    cpu_addr = 32'h400; cpu_rd_req = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_wr_req) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL mid_wb_enter: got mem_wr_req=0 for 20 cycles, required 1");
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if (mem_wr_req !== 1'b0 || mem_rd_req !== 1'b0) begin
      fails++; $display("FAIL mid_reset_req: got wr=%b rd=%b, required 0 0", mem_wr_req, mem_rd_req);
    end
    cpu_rd_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int l = 0; l < 256; l++) arch[l] = backing[l];
    access(0, 32'h004, 32'h0, 1, 0, "post_reset_read");
  endtask

  task automatic test_stats();
    access(0, 32'h008, 32'h0, 0, 0, "stat_hit1");
    access(0, 32'h00C, 32'h0, 0, 0, "stat_hit2");
    access(0, 32'h044, 32'h0, 1, 0, "stat_miss2");
`ifdef CACHE_STAT_EN
    tests++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd2) begin
      fails++; $display("FAIL stats: got hit=%0d miss=%0d, required 2 2", hit_cnt, miss_cnt);
    end
`else
    tests++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      fails++; $display("FAIL stats_off: got hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  initial begin
    for (int l = 0; l < 256; l++) begin
      for (int w = 0; w < 4; w++) begin
        backing[l][w*32 +: 32] = {l[7:0], 16'h0, 8'(w * 17)};
      end
    end
    test_reset();
    test_cold_read();
    test_write_hit();
    test_conflict();
    test_write_miss();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
